// File: rtl/c1541_track_loader_if.sv
// SD block-transfer handshake between the 1541 track loader and the SD host.
// The loader is the master: it drives the block address, count, buffer
// offset and the read/write requests. The host answers with sd_ack, which
// stays high for the whole transfer.
interface c1541_track_loader_if;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic [8:0]  sd_buf_base;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (
    output sd_lba,
    output sd_blk_cnt,
    output sd_buf_base,
    output sd_rd,
    output sd_wr,
    input  sd_ack
  );

  modport slave (
    input  sd_lba,
    input  sd_blk_cnt,
    input  sd_buf_base,
    input  sd_rd,
    input  sd_wr,
    output sd_ack
  );
endinterface

// File: rtl/c1541_track_loader.sv
// c1541_track_loader: clk_sys-side track cache controller for the 1541 drive.
// It follows the head position from the drive core, reads the matching track
// image from SD into the track buffer, and writes a modified track back on
// request. busy_o gates the GCR stages of the drive core.
//
// Optional feature macro: C1541_TRACK_WRITE_EN
//   defined   : save_track toggles trigger a write-back of the loaded track.
//   undefined : no write states, sd_wr stays 0, save toggles are ignored.
//
// A loaded or wanted track is identified by an 8-bit key:
//   gcr_mode : {1'b1, half-track}        (every half-track is its own image)
//   D64      : {1'b0, clamped track t}   (both half-tracks share one t)
// Everything about a transfer's address is derived from this key.
module c1541_track_loader #(
  parameter int GCR_BLOCKS    = 16,
  parameter int D64_MAX_TRACK = 40
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  gcr_mode_i,
  input  logic                  change_i,
  input  logic [6:0]            track_i,
  input  logic                  save_track_i,
  c1541_track_loader_if.master  sd,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2
`ifdef C1541_TRACK_WRITE_EN
    ,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
`endif
  } state_t;

  typedef struct packed {
    logic [31:0] lba;
    logic [5:0]  cnt;
    logic [8:0]  base;
  } addr_t;

  // Build the track key from a half-track number and the image layout.
  function automatic logic [7:0] key_of(input logic [6:0] half, input logic gcr);
    logic [6:0] t7;
    t7 = {1'b0, half[6:1]} + 7'd1;
    if (t7 > 7'(D64_MAX_TRACK)) begin
      t7 = 7'(D64_MAX_TRACK);
    end else begin
      t7 = t7;
    end
    if (gcr) begin
      return {1'b1, half};
    end else begin
      return {1'b0, t7};
    end
  endfunction

  // SD address, block count and buffer offset for a track key.
  function automatic addr_t calc_addr(input logic [7:0] key);
    addr_t      a;
    logic [5:0] t;
    logic [9:0] s;
    logic [4:0] n;
    logic [5:0] sum;
    t = key[5:0];
    if (key[7]) begin
      a.lba  = {25'd0, key[6:0]} * 32'(GCR_BLOCKS);
      a.cnt  = 6'(GCR_BLOCKS - 1);
      a.base = 9'd0;
    end else begin
      // Sector zones of a D64 image: 21/19/18/17 sectors per track.
      if (t <= 6'd17) begin
        s = ({4'd0, t} - 10'd1) * 10'd21;
        n = 5'd21;
      end else if (t <= 6'd24) begin
        s = 10'd357 + ({4'd0, t} - 10'd18) * 10'd19;
        n = 5'd19;
      end else if (t <= 6'd30) begin
        s = 10'd490 + ({4'd0, t} - 10'd25) * 10'd18;
        n = 5'd18;
      end else begin
        s = 10'd598 + ({4'd0, t} - 10'd31) * 10'd17;
        n = 5'd17;
      end
      // Sectors are 256 bytes; an odd start sector sits in the upper half
      // of its 512-byte block, so one extra half-block may be needed.
      sum    = {5'd0, s[0]} + {1'b0, n} + 6'd1;
      a.lba  = {23'd0, s[9:1]};
      a.base = {s[0], 8'd0};
      a.cnt  = (sum >> 1) - 6'd1;
    end
    return a;
  endfunction

  // Synchronisers and edge detectors
  logic [6:0] track_s1_q, track_s2_q, track_prev_q, wanted_q;
  logic       change_q;
  logic       change_edge_s;
  logic       save_edge_s;

  // FSM and transfer state
  state_t     state_q, state_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  addr_t      addr_q, addr_d;
  logic [7:0] xfer_key_q, xfer_key_d;
  logic [7:0] loaded_key_q, loaded_key_d;
  logic       loaded_valid_q, loaded_valid_d;
  logic       pend_q, pend_d;
  logic       stale_q, stale_d;
  logic       busy_q, busy_d;
  logic [7:0] wanted_key_s;

  // Bring the async track number into clk_sys and accept it once stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      track_s1_q   <= 7'd0;
      track_s2_q   <= 7'd0;
      track_prev_q <= 7'd0;
      wanted_q     <= 7'd0;
      change_q     <= 1'b0;
    end else begin
      track_s1_q   <= track_i;
      track_s2_q   <= track_s1_q;
      track_prev_q <= track_s2_q;
      if (track_s2_q == track_prev_q) begin
        wanted_q <= track_s2_q;
      end else begin
        wanted_q <= wanted_q;
      end
      change_q     <= change_i;
    end
  end

`ifdef C1541_TRACK_WRITE_EN
  logic save_s1_q, save_s2_q, save_s3_q;

  // Synchronise the save toggle; every edge is one write-back request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      save_s1_q <= 1'b0;
      save_s2_q <= 1'b0;
      save_s3_q <= 1'b0;
    end else begin
      save_s1_q <= save_track_i;
      save_s2_q <= save_s1_q;
      save_s3_q <= save_s2_q;
    end
  end

  assign save_edge_s = save_s2_q ^ save_s3_q;
`else
  logic unused_save_s;
  assign unused_save_s = save_track_i;
  assign save_edge_s   = 1'b0;
`endif

  assign change_edge_s = change_i & ~change_q;
  assign wanted_key_s  = key_of(wanted_q, gcr_mode_i);

  // State, request, address and cache-tag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      xfer_key_q     <= 8'd0;
      loaded_key_q   <= 8'd0;
      loaded_valid_q <= 1'b0;
      pend_q         <= 1'b0;
      stale_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      xfer_key_q     <= xfer_key_d;
      loaded_key_q   <= loaded_key_d;
      loaded_valid_q <= loaded_valid_d;
      pend_q         <= pend_d;
      stale_q        <= stale_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state logic: pick write-back or fetch, run the SD handshake.
  always_comb begin
    state_d        = state_q;
    rd_d           = 1'b0;
    wr_d           = 1'b0;
    addr_d         = addr_q;
    xfer_key_d     = xfer_key_q;
    loaded_key_d   = loaded_key_q;
    loaded_valid_d = loaded_valid_q;
    pend_d         = pend_q | save_edge_s;
    stale_d        = stale_q;

    case (state_q)
      ST_IDLE: begin
`ifdef C1541_TRACK_WRITE_EN
        if (pend_q && loaded_valid_q && !change_edge_s) begin
          state_d = ST_WR_REQ;
          wr_d    = 1'b1;
          addr_d  = calc_addr(loaded_key_q);
          pend_d  = save_edge_s;
          stale_d = 1'b0;
        end else
`endif
        if (!loaded_valid_q || (wanted_key_s != loaded_key_q)) begin
          state_d    = ST_RD_REQ;
          rd_d       = 1'b1;
          addr_d     = calc_addr(wanted_key_s);
          xfer_key_d = wanted_key_s;
          stale_d    = 1'b0;
          // Nothing valid to save: a pending save has no image behind it.
          if (!loaded_valid_q) begin
            pend_d = save_edge_s;
          end else begin
            pend_d = pend_q | save_edge_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (sd.sd_ack) begin
          state_d = ST_RD_WAIT;
          rd_d    = 1'b0;
        end else begin
          rd_d    = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (!sd.sd_ack) begin
          state_d        = ST_IDLE;
          loaded_key_d   = xfer_key_q;
          // A mount during the read means the buffer holds the old image.
          loaded_valid_d = ~stale_q;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
`ifdef C1541_TRACK_WRITE_EN
      ST_WR_REQ: begin
        if (sd.sd_ack) begin
          state_d = ST_WR_WAIT;
          wr_d    = 1'b0;
        end else begin
          wr_d    = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (!sd.sd_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new image invalidates the cache and discards any pending save.
    if (change_edge_s) begin
      loaded_valid_d = 1'b0;
      pend_d         = 1'b0;
      if (state_q != ST_IDLE) begin
        stale_d = 1'b1;
      end else begin
        stale_d = stale_d;
      end
    end else begin
      loaded_valid_d = loaded_valid_d;
    end

    busy_d = (state_d != ST_IDLE) | pend_d | ~loaded_valid_d |
             (wanted_key_s != loaded_key_d);
  end

  assign sd.sd_lba      = addr_q.lba;
  assign sd.sd_blk_cnt  = addr_q.cnt;
  assign sd.sd_buf_base = addr_q.base;
  assign sd.sd_rd       = rd_q;
  assign sd.sd_wr       = wr_q;
  assign busy_o         = busy_q;

endmodule
